uart_instr_loader: RTL

- Boot-time program loader sitting directly upstream of the instruction fetch stage.
- Receives a program image over a serial UART line and assembles little-endian 32-bit instruction words.
- Drives the write_byte_address / write_instr_data / write_instr_valid port group into instruction memory.
- Raises start once the full image is written, which hands the pipeline over to PC-driven fetch.

---
 rtl/uart_instr_loader_if.sv | 28 ++
 rtl/uart_instr_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_instr_loader_if.sv
// Instruction-memory write port plus loader status flags.
// The loader drives every signal; instruction memory and the fetch stage observe them.
interface uart_instr_loader_if;
    logic [31:0] write_byte_address;
    logic [31:0] write_instr_data;
    logic        write_instr_valid;
    logic        start;
    logic        load_error;
    logic        rx_error;

    modport master (
        output write_byte_address,
        output write_instr_data,
        output write_instr_valid,
        output start,
        output load_error,
        output rx_error
    );

    modport slave (
        input write_byte_address,
        input write_instr_data,
        input write_instr_valid,
        input start,
        input load_error,
        input rx_error
    );
endinterface

// File: rtl/uart_instr_loader.sv
// Boot loader: 8N1 UART receiver feeding a length-prefixed little-endian
// word assembler that writes instruction memory, then raises start.
module uart_instr_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_WORDS    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    uart_instr_loader_if.master wr
);
    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {LdLen, LdData, LdDone, LdError} ld_state_e;

    rx_state_e   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_armed;
    logic [31:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        bit_done;
    logic        byte_valid;

    ld_state_e   ld_state;
    logic [1:0]  byte_idx;
    logic [31:0] len;
    logic [31:0] word_idx;
    logic [31:0] word_buf;
    logic [31:0] len_next;
    logic [31:0] word_next;

    assign bit_done   = (clk_cnt == CLKS_PER_BIT - 1);
    assign byte_valid = (rx_state == RxStop) && bit_done && rx_sync;
    // Shifting right by a byte leaves the first byte received in bits [7:0].
    assign len_next   = {shift_reg, len[31:8]};
    assign word_next  = {shift_reg, word_buf[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_armed    <= 1'b0;
            rx_state    <= RxIdle;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            wr.rx_error <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            case (rx_state)
                RxIdle: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    // After a framing error the line must go idle before a new start.
                    if (!rx_sync && rx_armed) begin
                        rx_state <= RxStart;
                    end else if (rx_sync) begin
                        rx_armed <= 1'b1;
                    end
                end
                RxStart: begin
                    if (clk_cnt == HalfBit - 1) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        clk_cnt <= clk_cnt + 32'd1;
                    end
                end
                RxData: begin
                    if (bit_done) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RxStop;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 32'd1;
                    end
                end
                RxStop: begin
                    if (bit_done) begin
                        clk_cnt  <= '0;
                        rx_state <= RxIdle;
                        if (!rx_sync) begin
                            wr.rx_error <= 1'b1;
                            rx_armed    <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 32'd1;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state              <= LdLen;
            byte_idx              <= '0;
            len                   <= '0;
            word_idx              <= '0;
            word_buf              <= '0;
            wr.write_byte_address <= '0;
            wr.write_instr_data   <= '0;
            wr.write_instr_valid  <= 1'b0;
            wr.start              <= 1'b0;
            wr.load_error         <= 1'b0;
        end else begin
            wr.write_instr_valid <= 1'b0;
            case (ld_state)
                LdLen: begin
                    if (byte_valid) begin
                        len      <= len_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (len_next == 32'd0) begin
                                ld_state <= LdDone;
                                wr.start <= 1'b1;
                            end else if (len_next > MAX_WORDS) begin
                                ld_state      <= LdError;
                                wr.load_error <= 1'b1;
                            end else begin
                                ld_state <= LdData;
                            end
                        end
                    end
                end
                LdData: begin
                    if (byte_valid) begin
                        word_buf <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr.write_instr_valid  <= 1'b1;
                            wr.write_instr_data   <= word_next;
                            wr.write_byte_address <= {word_idx[29:0], 2'b00};
                            word_idx              <= word_idx + 32'd1;
                            // start follows in the next cycle, from LdDone.
                            if (word_idx + 32'd1 == len) begin
                                ld_state <= LdDone;
                            end
                        end
                    end
                end
                LdDone:  wr.start      <= 1'b1;
                LdError: wr.load_error <= 1'b1;
                default: ld_state      <= LdLen;
            endcase
        end
    end
endmodule
